bfly_r2: RTL and testbench

- Pipelined radix-2 complex butterfly for the FFT datapath.
- Takes two complex 16-bit samples A and B and produces X0 = A+B and X1 = A-B at full (DATA_WIDTH+1)-bit precision.
- Each of its four outputs (re/im of X0 and X1) feeds a downstream 16-bit saturation stage.
- Valid/ready handshake on both sides, 1 sample pair per cycle sustained, and a running overflow-event counter for block-exponent control.

---
 rtl/bfly_r2_pkg.sv | 35 +++
 rtl/bfly_r2_ovf_det.sv | 31 +++
 rtl/bfly_r2.sv | 199 +++++++++++++++++++
 tb/tb_bfly_r2.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfly_r2_pkg.sv
// ---------------------------------------------------------------------------
// bfly_r2_pkg
// Shared definitions for the radix-2 butterfly slice.
//   DATA_WIDTH  : input component width (override with the DATA_WIDTH macro)
//   OVF_CNT_W   : width of the overflow event counter
//   cplx_t      : complex sample, W-bit components
//   cplx_ext_t  : complex result, W+1-bit components
//   comp_ovf()  : downstream saturation trigger for one W+1-bit component
// Optional feature macro used by the slice: BFLY_SCALE_EN (see bfly_r2.sv).
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package bfly_r2_pkg;

  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int OVF_CNT_W  = 16;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic [DATA_WIDTH:0] re;
    logic [DATA_WIDTH:0] im;
  } cplx_ext_t;

  // A W+1-bit result no longer fits in W bits when its top two bits differ.
  function automatic logic comp_ovf(input logic [DATA_WIDTH:0] v);
    return v[DATA_WIDTH] ^ v[DATA_WIDTH-1];
  endfunction

endpackage

// File: rtl/bfly_r2_ovf_det.sv
// ---------------------------------------------------------------------------
// bfly_ovf_det
// Combinational any-overflow detector for the four butterfly results.
// A component overflows when bit W differs from bit W-1, i.e. the value
// would clip in the downstream W-bit saturation stage.
// Ports:
//   i_x0_re, i_x0_im, i_x1_re, i_x1_im : W+1-bit results
//   o_any_ovf                          : 1 when any component overflows
// ---------------------------------------------------------------------------
module bfly_ovf_det
  import bfly_r2_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic [W:0] i_x0_re,
  input  logic [W:0] i_x0_im,
  input  logic [W:0] i_x1_re,
  input  logic [W:0] i_x1_im,
  output logic       o_any_ovf
);

  logic [3:0] w_ovf;

  assign w_ovf[0] = i_x0_re[W] ^ i_x0_re[W-1];
  assign w_ovf[1] = i_x0_im[W] ^ i_x0_im[W-1];
  assign w_ovf[2] = i_x1_re[W] ^ i_x1_re[W-1];
  assign w_ovf[3] = i_x1_im[W] ^ i_x1_im[W-1];

  assign o_any_ovf = |w_ovf;

endmodule

// File: rtl/bfly_r2.sv
// ---------------------------------------------------------------------------
// bfly_r2
// Two-stage pipelined radix-2 complex butterfly: X0 = A+B, X1 = A-B at
// W+1-bit precision, plus a saturating count of output transfers carrying
// any component that would overflow a W-bit saturation stage.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is a function of pipeline occupancy and out_ready only (never of
// in_valid); a stalled stage keeps its data and valid bit unchanged, so the
// outputs are stable while out_valid && !out_ready.
//
// Ports:
//   clock, reset_n         : clock, synchronous active-low reset
//   in_valid / in_ready    : input handshake for the A/B pair
//   a_re, a_im, b_re, b_im : W-bit two's-complement inputs
//   out_valid / out_ready  : output handshake
//   x0_re, x0_im           : A+B, W+1 bits
//   x1_re, x1_im           : A-B, W+1 bits
//   ovf_clr                : clear ovf_cnt (wins over a same-cycle increment)
//   ovf_cnt                : saturating overflow event counter
//
// Macro BFLY_SCALE_EN: when defined, every result is arithmetic-shifted
// right by one before the first stage captures it, so nothing ever
// overflows; the counter logic stays in place.
// ---------------------------------------------------------------------------
module bfly_r2
  import bfly_r2_pkg::*;
#(
  parameter int W     = DATA_WIDTH,
  parameter int CNT_W = OVF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_re,
  input  logic [W-1:0]     a_im,
  input  logic [W-1:0]     b_re,
  input  logic [W-1:0]     b_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       x0_re,
  output logic [W:0]       x0_im,
  output logic [W:0]       x1_re,
  output logic [W:0]       x1_im,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  // -------------------------------------------------------------------------
  // Stage enables
  // -------------------------------------------------------------------------
  logic r_s1_v;
  logic r_s2_v;
  logic w_s1_en;
  logic w_s2_en;

  assign w_s2_en  = !r_s2_v || out_ready;
  assign w_s1_en  = !r_s1_v || w_s2_en;
  assign in_ready = w_s1_en;

  // -------------------------------------------------------------------------
  // Butterfly arithmetic (exact at W+1 bits)
  // -------------------------------------------------------------------------
  logic [W:0] w_a_re_x;
  logic [W:0] w_a_im_x;
  logic [W:0] w_b_re_x;
  logic [W:0] w_b_im_x;
  logic [W:0] w_sum_re;
  logic [W:0] w_sum_im;
  logic [W:0] w_dif_re;
  logic [W:0] w_dif_im;

  assign w_a_re_x = {a_re[W-1], a_re};
  assign w_a_im_x = {a_im[W-1], a_im};
  assign w_b_re_x = {b_re[W-1], b_re};
  assign w_b_im_x = {b_im[W-1], b_im};

  assign w_sum_re = w_a_re_x + w_b_re_x;
  assign w_sum_im = w_a_im_x + w_b_im_x;
  assign w_dif_re = w_a_re_x - w_b_re_x;
  assign w_dif_im = w_a_im_x - w_b_im_x;

  logic [W:0] w_x0_re;
  logic [W:0] w_x0_im;
  logic [W:0] w_x1_re;
  logic [W:0] w_x1_im;

`ifdef BFLY_SCALE_EN
  // Halve every result (truncation toward -inf); the sign bit is replicated
  // so the value stays a valid W+1-bit number that always fits in W bits.
  assign w_x0_re = $signed(w_sum_re) >>> 1;
  assign w_x0_im = $signed(w_sum_im) >>> 1;
  assign w_x1_re = $signed(w_dif_re) >>> 1;
  assign w_x1_im = $signed(w_dif_im) >>> 1;
`else
  assign w_x0_re = w_sum_re;
  assign w_x0_im = w_sum_im;
  assign w_x1_re = w_dif_re;
  assign w_x1_im = w_dif_im;
`endif

  // -------------------------------------------------------------------------
  // Stage 1: capture results on input transfer
  // -------------------------------------------------------------------------
  logic [W:0] r_s1_x0_re;
  logic [W:0] r_s1_x0_im;
  logic [W:0] r_s1_x1_re;
  logic [W:0] r_s1_x1_im;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s1_v     <= 1'b0;
      r_s1_x0_re <= '0;
      r_s1_x0_im <= '0;
      r_s1_x1_re <= '0;
      r_s1_x1_im <= '0;
    end else if (w_s1_en) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_x0_re <= w_x0_re;
        r_s1_x0_im <= w_x0_im;
        r_s1_x1_re <= w_x1_re;
        r_s1_x1_im <= w_x1_im;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Overflow detection on the stage-1 results, registered alongside them
  // -------------------------------------------------------------------------
  logic w_s1_ovf;

  bfly_ovf_det #(
    .W (W)
  ) u_ovf_det (
    .i_x0_re   (r_s1_x0_re),
    .i_x0_im   (r_s1_x0_im),
    .i_x1_re   (r_s1_x1_re),
    .i_x1_im   (r_s1_x1_im),
    .o_any_ovf (w_s1_ovf)
  );

  // -------------------------------------------------------------------------
  // Stage 2: output register
  // -------------------------------------------------------------------------
  logic [W:0] r_s2_x0_re;
  logic [W:0] r_s2_x0_im;
  logic [W:0] r_s2_x1_re;
  logic [W:0] r_s2_x1_im;
  logic       r_s2_ovf;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s2_v     <= 1'b0;
      r_s2_x0_re <= '0;
      r_s2_x0_im <= '0;
      r_s2_x1_re <= '0;
      r_s2_x1_im <= '0;
      r_s2_ovf   <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_x0_re <= r_s1_x0_re;
        r_s2_x0_im <= r_s1_x0_im;
        r_s2_x1_re <= r_s1_x1_re;
        r_s2_x1_im <= r_s1_x1_im;
        r_s2_ovf   <= w_s1_ovf;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign x0_re     = r_s2_x0_re;
  assign x0_im     = r_s2_x0_im;
  assign x1_re     = r_s2_x1_re;
  assign x1_im     = r_s2_x1_im;

  // -------------------------------------------------------------------------
  // Overflow event counter: counts output transfers, saturates at all-ones
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] r_ovf_cnt;
  logic             w_out_fire;

  assign w_out_fire = r_s2_v && out_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ovf_cnt <= '0;
    end else if (ovf_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_out_fire && r_s2_ovf && (r_ovf_cnt != {CNT_W{1'b1}})) begin
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_bfly_r2.sv
// ---------------------------------------------------------------------------
// tb_bfly_r2
// Directed bench for bfly_r2 in its default build (BFLY_SCALE_EN undefined).
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 1-2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_bfly_r2;
  import bfly_r2_pkg::*;

  localparam int W  = DATA_WIDTH;
  localparam int CW = OVF_CNT_W;
  localparam int RW = 4 * (W + 1);

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic          ovf_clr   = 1'b0;
  logic [W-1:0]  a_re = '0;
  logic [W-1:0]  a_im = '0;
  logic [W-1:0]  b_re = '0;
  logic [W-1:0]  b_im = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W:0]    x0_re;
  logic [W:0]    x0_im;
  logic [W:0]    x1_re;
  logic [W:0]    x1_im;
  logic [CW-1:0] ovf_cnt;

  always #5 clock = ~clock;

  bfly_r2 #(.W(W), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x0_re     (x0_re),
    .x0_im     (x0_im),
    .x1_re     (x1_re),
    .x1_im     (x1_im),
    .ovf_clr   (ovf_clr),
    .ovf_cnt   (ovf_cnt)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver helpers
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] ar, input logic [W-1:0] ai,
                       input logic [W-1:0] br, input logic [W-1:0] bi);
    a_re = ar;
    a_im = ai;
    b_re = br;
    b_im = bi;
  endtask

  function automatic logic [RW-1:0] outs();
    return {x0_re, x0_im, x1_re, x1_im};
  endfunction

  // Reference butterfly for the streaming pattern.
  function automatic logic [RW-1:0] ref_bfly(input logic [W-1:0] ar,
      input logic [W-1:0] ai, input logic [W-1:0] br, input logic [W-1:0] bi);
    logic signed [W:0] sar, sai, sbr, sbi;
    logic [W:0] s0r, s0i, s1r, s1i;
    sar = $signed(ar);
    sai = $signed(ai);
    sbr = $signed(br);
    sbi = $signed(bi);
    s0r = sar + sbr;
    s0i = sai + sbi;
    s1r = sar - sbr;
    s1i = sai - sbi;
    return {s0r, s0i, s1r, s1i};
  endfunction

  function automatic logic [4*W-1:0] stream_pair(input int i);
    logic [W-1:0] ar, ai, br, bi;
    ar = W'(i * 256);
    ai = W'(-i);
    br = W'(16 + i);
    bi = W'(3 * i);
    return {ar, ai, br, bi};
  endfunction

  // -------------------------------------------------------------------------
  // Directed vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0]  a_re, a_im, b_re, b_im;
    logic [W:0]    x0_re, x0_im, x1_re, x1_im;
    logic [CW-1:0] cnt;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [RW-1:0] cur;
    logic [RW-1:0] held;
    logic [4*W-1:0] p;
    bit hold_chk;
    bit in_fire;
    bit out_fire;
    int sent;
    int got;
    int last_c;

    vecs[0] = '{16'h0100, 16'hFF00, 16'h0010, 16'h0020,
                17'h00110, 17'h1FF20, 17'h000F0, 17'h1FEE0, 16'd0};
    vecs[1] = '{16'h7FFF, 16'h0000, 16'h0001, 16'h0000,
                17'h08000, 17'h00000, 17'h07FFE, 17'h00000, 16'd1};
    vecs[2] = '{16'h8000, 16'h8000, 16'h8000, 16'h7FFF,
                17'h10000, 17'h1FFFF, 17'h00000, 17'h10001, 16'd2};
    vecs[3] = '{16'h1234, 16'h0005, 16'h1111, 16'hFFFB,
                17'h02345, 17'h00000, 17'h00123, 17'h0000A, 16'd2};
    vecs[4] = '{16'hC000, 16'h4000, 16'hC000, 16'h4000,
                17'h18000, 17'h08000, 17'h00000, 17'h00000, 16'd3};
    vecs[5] = '{16'hFFFF, 16'h0001, 16'h0001, 16'hFFFF,
                17'h00000, 17'h00000, 17'h1FFFE, 17'h00002, 16'd3};
    vecs[6] = '{16'h8000, 16'h0000, 16'h0001, 16'h0000,
                17'h18001, 17'h00000, 17'h17FFF, 17'h00000, 16'd4};

    // ---- reset ------------------------------------------------------------
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ovf_cnt", ovf_cnt, 0);
    check("rst_data", outs(), 0);

    // ---- table: single pairs, two-cycle latency ---------------------------
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].a_re, vecs[i].a_im, vecs[i].b_re, vecs[i].b_im);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d_lat1", i), out_valid, 0);
      step();
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_data", i), outs(),
            {vecs[i].x0_re, vecs[i].x0_im, vecs[i].x1_re, vecs[i].x1_im});
      step();
      check($sformatf("vec%0d_cnt", i), ovf_cnt, vecs[i].cnt);
      check($sformatf("vec%0d_drain", i), out_valid, 0);
    end

    // ---- counter clear, then saturation -----------------------------------
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr_cnt", ovf_cnt, 0);

    drive(16'h7FFF, 16'h0000, 16'h0001, 16'h0000);
    in_valid = 1'b1;
    for (int n = 0; n < 65534; n++) step();
    in_valid = 1'b0;
    step();
    step();
    check("cnt_fffe", ovf_cnt, 16'hFFFE);

    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
    check("cnt_ffff", ovf_cnt, 16'hFFFF);

    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("cnt_sat_hold", ovf_cnt, 16'hFFFF);

    // clear in the same cycle as an overflowing output transfer
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("clr_race_valid", out_valid, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr_race_cnt", ovf_cnt, 0);
    check("clr_race_drain", out_valid, 0);

    // ---- streaming 8 pairs with a 3-cycle output stall --------------------
    sent     = 0;
    got      = 0;
    last_c   = -1;
    hold_chk = 1'b0;
    held     = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 8);
      p = stream_pair(sent);
      drive(p[4*W-1:3*W], p[3*W-1:2*W], p[2*W-1:W], p[W-1:0]);
      #1;
      check($sformatf("str_c%0d_in_ready", c), in_ready,
            (exp_q.size() < 2) || out_ready);
      if (hold_chk) begin
        check($sformatf("str_c%0d_hold_valid", c), out_valid, 1);
        check($sformatf("str_c%0d_hold_data", c), outs(), held);
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      cur      = outs();
      hold_chk = out_valid && !out_ready;
      held     = cur;
      @(posedge clock);
      #1;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          check($sformatf("str_c%0d_unexpected", c), 1, 0);
        end else begin
          check($sformatf("str_out%0d", got), cur, exp_q.pop_front());
        end
        got++;
        last_c = c;
      end
      if (in_fire) begin
        exp_q.push_back(ref_bfly(p[4*W-1:3*W], p[3*W-1:2*W], p[2*W-1:W], p[W-1:0]));
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("str_count", got, 8);
    check("str_last_cycle", last_c, 12);
    check("str_queue_empty", exp_q.size(), 0);
    check("str_cnt", ovf_cnt, 0);
    step();
    check("str_drain", out_valid, 0);

    // ---- reset with two pairs in flight -----------------------------------
    drive(16'h7FFF, 16'h0000, 16'h0001, 16'h0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("pre_rst_cnt", ovf_cnt, 1);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    step();
    drive(16'h8000, 16'h0000, 16'h0001, 16'h0000);
    step();
    in_valid = 1'b0;
    check("inflight_valid", out_valid, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cnt", ovf_cnt, 0);
    check("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("post_rst_idle%0d", k), out_valid, 0);
      step();
    end
    drive(vecs[0].a_re, vecs[0].a_im, vecs[0].b_re, vecs[0].b_im);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", outs(),
          {vecs[0].x0_re, vecs[0].x0_im, vecs[0].x1_re, vecs[0].x1_im});
    step();
    check("post_rst_cnt", ovf_cnt, 0);

    // ---- report -----------------------------------------------------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
